id_ex_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core.
- Captures the control unit outputs plus decoded operands/addresses every cycle and presents them to EX.
- Owns the pipeline's load-use hazard detection: inserts bubbles into EX and stalls PC and IF/ID.
- Handles flush on EX redirect (taken branch/jump) and hold on downstream stall.

---
 rtl/id_ex_reg_if.sv | 53 +++++
 rtl/id_ex_reg.sv | 94 +++++++++
 tb/tb_id_ex_reg.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: control encodings and the ID->EX bundle (master = ID/hazard side, slave = ID/EX register)
package id_ex_pkg;
  typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_op_t;
  typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMDATA, WRSRC_PC4, WRSRC_IMM} reg_wr_src_t;
  typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} alu_src1_t;
  typedef enum logic {SRC2_REG2, SRC2_IMM} alu_src2_t;
  typedef enum logic [3:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU} alu_op_t;
  typedef enum logic [3:0] {MEM_NOP, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW} mem_op_t;
endpackage

interface id_ex_reg_if #(parameter int XLEN = 32);
  import id_ex_pkg::*;
  logic id_valid, id_reg_do_write, id_mem_do_write, id_mem_do_read, id_do_branch, id_do_jump;
  comp_op_t id_comp_ctrl;
  reg_wr_src_t id_reg_wr_src;
  alu_src1_t id_alu_src1;
  alu_src2_t id_alu_src2;
  alu_op_t id_alu_ctrl;
  mem_op_t id_mem_ctrl;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic ex_redirect, ex_stall;
  logic ex_valid, ex_reg_do_write, ex_mem_do_write, ex_mem_do_read, ex_do_branch, ex_do_jump;
  comp_op_t ex_comp_ctrl;
  reg_wr_src_t ex_reg_wr_src;
  alu_src1_t ex_alu_src1;
  alu_src2_t ex_alu_src2;
  alu_op_t ex_alu_ctrl;
  mem_op_t ex_mem_ctrl;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic id_stall, load_use;
  modport master (
    output id_valid, id_reg_do_write, id_mem_do_write, id_mem_do_read, id_do_branch, id_do_jump,
           id_comp_ctrl, id_reg_wr_src, id_alu_src1, id_alu_src2, id_alu_ctrl, id_mem_ctrl,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr,
           ex_redirect, ex_stall,
    input  ex_valid, ex_reg_do_write, ex_mem_do_write, ex_mem_do_read, ex_do_branch, ex_do_jump,
           ex_comp_ctrl, ex_reg_wr_src, ex_alu_src1, ex_alu_src2, ex_alu_ctrl, ex_mem_ctrl,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
           id_stall, load_use
  );
  modport slave (
    input  id_valid, id_reg_do_write, id_mem_do_write, id_mem_do_read, id_do_branch, id_do_jump,
           id_comp_ctrl, id_reg_wr_src, id_alu_src1, id_alu_src2, id_alu_ctrl, id_mem_ctrl,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr,
           ex_redirect, ex_stall,
    output ex_valid, ex_reg_do_write, ex_mem_do_write, ex_mem_do_read, ex_do_branch, ex_do_jump,
           ex_comp_ctrl, ex_reg_wr_src, ex_alu_src1, ex_alu_src2, ex_alu_ctrl, ex_mem_ctrl,
           ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
           id_stall, load_use
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use detection, flush and hold; ID_EX_PERF_CNT_EN adds perf counters
module id_ex_reg import id_ex_pkg::*; #(
  parameter int XLEN = 32,
  parameter int PERF_W = 32
) (
  input logic clk,
  input logic rst,
  id_ex_reg_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_bubbles,
  output logic [PERF_W-1:0] perf_flushes,
  output logic [PERF_W-1:0] perf_hold_cycles
`endif
);
  typedef struct packed {
    logic valid;
    logic reg_do_write;
    logic mem_do_write;
    logic mem_do_read;
    logic do_branch;
    logic do_jump;
    comp_op_t comp_ctrl;
    reg_wr_src_t reg_wr_src;
    alu_src1_t alu_src1;
    alu_src2_t alu_src2;
    alu_op_t alu_ctrl;
    mem_op_t mem_ctrl;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
  } stage_t;
  localparam stage_t BUBBLE = '0;
  stage_t id_s, ex_q, ex_d;
  logic load_use;
  assign id_s = '{
    valid: bus.id_valid, reg_do_write: bus.id_reg_do_write, mem_do_write: bus.id_mem_do_write,
    mem_do_read: bus.id_mem_do_read, do_branch: bus.id_do_branch, do_jump: bus.id_do_jump,
    comp_ctrl: bus.id_comp_ctrl, reg_wr_src: bus.id_reg_wr_src, alu_src1: bus.id_alu_src1,
    alu_src2: bus.id_alu_src2, alu_ctrl: bus.id_alu_ctrl, mem_ctrl: bus.id_mem_ctrl,
    pc: bus.id_pc, rs1_data: bus.id_rs1_data, rs2_data: bus.id_rs2_data, imm: bus.id_imm,
    rs1_addr: bus.id_rs1_addr, rs2_addr: bus.id_rs2_addr, rd_addr: bus.id_rd_addr
  };
  assign load_use = bus.id_valid & ex_q.valid & ex_q.mem_do_read & (|ex_q.rd_addr) &
                    (ex_q.rd_addr == bus.id_rs1_addr | ex_q.rd_addr == bus.id_rs2_addr);
  assign bus.load_use = load_use;
  assign bus.id_stall = !bus.ex_redirect & (bus.ex_stall | load_use);
  // next EX contents: flush beats hold, hold beats hazard bubble, otherwise take ID
  always_comb
    ex_d = bus.ex_redirect ? BUBBLE : bus.ex_stall ? ex_q : (load_use || !bus.id_valid) ? BUBBLE : id_s;
  // EX stage register
  always_ff @(posedge clk)
    ex_q <= rst ? BUBBLE : ex_d;
  assign bus.ex_valid = ex_q.valid;
  assign bus.ex_reg_do_write = ex_q.reg_do_write;
  assign bus.ex_mem_do_write = ex_q.mem_do_write;
  assign bus.ex_mem_do_read = ex_q.mem_do_read;
  assign bus.ex_do_branch = ex_q.do_branch;
  assign bus.ex_do_jump = ex_q.do_jump;
  assign bus.ex_comp_ctrl = ex_q.comp_ctrl;
  assign bus.ex_reg_wr_src = ex_q.reg_wr_src;
  assign bus.ex_alu_src1 = ex_q.alu_src1;
  assign bus.ex_alu_src2 = ex_q.alu_src2;
  assign bus.ex_alu_ctrl = ex_q.alu_ctrl;
  assign bus.ex_mem_ctrl = ex_q.mem_ctrl;
  assign bus.ex_pc = ex_q.pc;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_imm = ex_q.imm;
  assign bus.ex_rs1_addr = ex_q.rs1_addr;
  assign bus.ex_rs2_addr = ex_q.rs2_addr;
  assign bus.ex_rd_addr = ex_q.rd_addr;
`ifdef ID_EX_PERF_CNT_EN
  logic bubble_evt, flush_evt, hold_evt;
  assign bubble_evt = !bus.ex_redirect & !bus.ex_stall & load_use;
  assign flush_evt = bus.ex_redirect & (ex_q.valid | bus.id_valid);
  assign hold_evt = bus.ex_stall & !bus.ex_redirect;
  // event counters, wrapping
  always_ff @(posedge clk)
    if (rst) begin
      perf_bubbles <= '0;
      perf_flushes <= '0;
      perf_hold_cycles <= '0;
    end else begin
      perf_bubbles <= perf_bubbles + PERF_W'(bubble_evt);
      perf_flushes <= perf_flushes + PERF_W'(flush_evt);
      perf_hold_cycles <= perf_hold_cycles + PERF_W'(hold_evt);
    end
`endif
endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: table-driven check of capture, load-use bubble, flush, hold and reset
module tb_id_ex_reg;
  import id_ex_pkg::*;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int errors = 0;
  id_ex_reg_if #(.XLEN(32)) bus();
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles, perf_flushes, perf_hold_cycles;
  id_ex_reg #(.XLEN(32), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave),
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes), .perf_hold_cycles(perf_hold_cycles));
`else
  id_ex_reg #(.XLEN(32), .PERF_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif
  always #5 clk = ~clk;

  typedef struct {
    logic rst, v, mrd;
    alu_op_t alu;
    logic [31:0] pc;
    logic [4:0] rd, rs1, rs2;
    logic redir, stall;
    logic lu, st, ev;
    alu_op_t ealu;
    logic [31:0] epc;
    logic [4:0] erd;
    logic emrd;
  } vec_t;
  vec_t q[$];

  function automatic vec_t mk(logic r, logic v, logic mrd, alu_op_t alu, logic [31:0] pc,
                              logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic redir, logic stall,
                              logic lu, logic st, logic ev, alu_op_t ealu, logic [31:0] epc,
                              logic [4:0] erd, logic emrd);
    vec_t t;
    t.rst = r; t.v = v; t.mrd = mrd; t.alu = alu; t.pc = pc; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
    t.redir = redir; t.stall = stall; t.lu = lu; t.st = st; t.ev = ev; t.ealu = ealu;
    t.epc = epc; t.erd = erd; t.emrd = emrd;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    rst = t.rst;
    bus.id_valid = t.v;
    bus.id_reg_do_write = t.v;
    bus.id_mem_do_write = 1'b0;
    bus.id_mem_do_read = t.mrd;
    bus.id_do_branch = 1'b0;
    bus.id_do_jump = 1'b0;
    bus.id_comp_ctrl = BR_NOP;
    bus.id_reg_wr_src = t.mrd ? WRSRC_MEMDATA : WRSRC_ALURES;
    bus.id_alu_src1 = SRC1_REG1;
    bus.id_alu_src2 = t.mrd ? SRC2_IMM : SRC2_REG2;
    bus.id_alu_ctrl = t.alu;
    bus.id_mem_ctrl = t.mrd ? MEM_LW : MEM_NOP;
    bus.id_pc = t.pc;
    bus.id_rs1_data = t.pc + 32'd1;
    bus.id_rs2_data = t.pc + 32'd2;
    bus.id_imm = t.pc + 32'd3;
    bus.id_rs1_addr = t.rs1;
    bus.id_rs2_addr = t.rs2;
    bus.id_rd_addr = t.rd;
    bus.ex_redirect = t.redir;
    bus.ex_stall = t.stall;
  endtask

  initial begin
    //      rst v mrd alu      pc     rd rs1 rs2 rdr stl | lu st ev ealu     epc    erd emrd
    q.push_back(mk(1, 1, 1, ALU_ADD, 32'h55,  9, 9, 9, 0, 0, 0, 0, 0, ALU_NOP, 32'h0,   0, 0));
    q.push_back(mk(0, 1, 0, ALU_ADD, 32'h100, 3, 1, 2, 0, 0, 0, 0, 1, ALU_ADD, 32'h100, 3, 0));
    q.push_back(mk(0, 1, 1, ALU_ADD, 32'h104, 5, 3, 4, 0, 0, 0, 0, 1, ALU_ADD, 32'h104, 5, 1));
    q.push_back(mk(0, 1, 0, ALU_SUB, 32'h108, 6, 1, 5, 0, 0, 1, 1, 0, ALU_NOP, 32'h0,   0, 0));
    q.push_back(mk(0, 1, 0, ALU_SUB, 32'h108, 6, 1, 5, 0, 0, 0, 0, 1, ALU_SUB, 32'h108, 6, 0));
    q.push_back(mk(0, 1, 1, ALU_ADD, 32'h10c, 0, 6, 7, 0, 0, 0, 0, 1, ALU_ADD, 32'h10c, 0, 1));
    q.push_back(mk(0, 1, 0, ALU_XOR, 32'h110, 8, 0, 0, 0, 0, 0, 0, 1, ALU_XOR, 32'h110, 8, 0));
    q.push_back(mk(0, 1, 1, ALU_ADD, 32'h114, 7, 8, 1, 0, 0, 0, 0, 1, ALU_ADD, 32'h114, 7, 1));
    q.push_back(mk(0, 1, 0, ALU_OR,  32'h118, 2, 7, 0, 1, 1, 1, 0, 0, ALU_NOP, 32'h0,   0, 0));
    q.push_back(mk(0, 0, 1, ALU_ADD, 32'h11c, 4, 1, 2, 0, 0, 0, 0, 0, ALU_NOP, 32'h0,   0, 0));
    q.push_back(mk(0, 1, 0, ALU_AND, 32'h200, 10, 1, 2, 0, 0, 0, 0, 1, ALU_AND, 32'h200, 10, 0));
    q.push_back(mk(0, 1, 0, ALU_SLL, 32'h204, 11, 1, 2, 0, 1, 0, 1, 1, ALU_AND, 32'h200, 10, 0));
    q.push_back(mk(0, 1, 0, ALU_SRL, 32'h208, 12, 3, 4, 0, 1, 0, 1, 1, ALU_AND, 32'h200, 10, 0));
    q.push_back(mk(0, 1, 0, ALU_SRA, 32'h20c, 13, 5, 6, 0, 1, 0, 1, 1, ALU_AND, 32'h200, 10, 0));
    q.push_back(mk(0, 1, 0, ALU_SLT, 32'h210, 14, 1, 2, 0, 0, 0, 0, 1, ALU_SLT, 32'h210, 14, 0));
    q.push_back(mk(0, 1, 1, ALU_ADD, 32'h300, 5, 1, 2, 0, 0, 0, 0, 1, ALU_ADD, 32'h300, 5, 1));
    q.push_back(mk(0, 1, 0, ALU_SUB, 32'h304, 6, 5, 2, 0, 1, 1, 1, 1, ALU_ADD, 32'h300, 5, 1));
    q.push_back(mk(0, 1, 0, ALU_SUB, 32'h304, 6, 5, 2, 0, 0, 1, 1, 0, ALU_NOP, 32'h0,   0, 0));
    q.push_back(mk(0, 1, 0, ALU_SUB, 32'h304, 6, 5, 2, 0, 0, 0, 0, 1, ALU_SUB, 32'h304, 6, 0));
    drive(q[0]);
    @(posedge clk);
    foreach (q[i]) begin
      @(negedge clk);
      drive(q[i]);
      #1;
      chk($sformatf("load_use[%0d]", i), 32'(bus.load_use), 32'(q[i].lu));
      chk($sformatf("id_stall[%0d]", i), 32'(bus.id_stall), 32'(q[i].st));
      @(posedge clk);
      #1;
      chk($sformatf("ex_valid[%0d]", i), 32'(bus.ex_valid), 32'(q[i].ev));
      chk($sformatf("ex_alu_ctrl[%0d]", i), 32'(bus.ex_alu_ctrl), 32'(q[i].ealu));
      chk($sformatf("ex_pc[%0d]", i), bus.ex_pc, q[i].epc);
      chk($sformatf("ex_rd_addr[%0d]", i), 32'(bus.ex_rd_addr), 32'(q[i].erd));
      chk($sformatf("ex_mem_do_read[%0d]", i), 32'(bus.ex_mem_do_read), 32'(q[i].emrd));
      chk($sformatf("ex_reg_do_write[%0d]", i), 32'(bus.ex_reg_do_write), 32'(q[i].ev));
      chk($sformatf("ex_rs1_data[%0d]", i), bus.ex_rs1_data, q[i].ev ? q[i].epc + 32'd1 : 32'd0);
    end
`ifdef ID_EX_PERF_CNT_EN
    chk("perf_bubbles", perf_bubbles, 32'd2);
    chk("perf_flushes", perf_flushes, 32'd1);
    chk("perf_hold_cycles", perf_hold_cycles, 32'd4);
`endif
    // reset arriving while a load-use hazard is pending
    @(negedge clk);
    drive(mk(0, 1, 1, ALU_ADD, 32'h400, 5, 1, 2, 0, 0, 0, 0, 0, ALU_NOP, 0, 0, 0));
    @(posedge clk);
    #1;
    chk("hz_setup_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'(MEM_LW));
    @(negedge clk);
    drive(mk(1, 1, 0, ALU_SUB, 32'h404, 6, 5, 2, 0, 0, 0, 0, 0, ALU_NOP, 0, 0, 0));
    #1;
    chk("rst_hz_load_use", 32'(bus.load_use), 32'd1);
    chk("rst_hz_id_stall", 32'(bus.id_stall), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_hz_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_hz_mem_ctrl", 32'(bus.ex_mem_ctrl), 32'(MEM_NOP));
    chk("rst_hz_wr_src", 32'(bus.ex_reg_wr_src), 32'(WRSRC_ALURES));
    chk("rst_hz_load_use_after", 32'(bus.load_use), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("rst_perf_hold", perf_hold_cycles, 32'd0);
    chk("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif
    // redirect with nothing valid in ID or EX is not a flush event but still empties EX
    @(negedge clk);
    drive(mk(0, 0, 0, ALU_ADD, 32'h500, 1, 1, 1, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0));
    #1;
    chk("idle_redir_id_stall", 32'(bus.id_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("idle_redir_ex_valid", 32'(bus.ex_valid), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
    chk("idle_redir_perf_flushes", perf_flushes, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
